// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_pkg
// Brief    : Shared constants and FSM state type for the data memory responder.
// Revision : 1.0
// ============================================================================
package data_mem_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;
    localparam logic [1:0] ALIGN_MASK = 2'b11;
    localparam int         WORD_BYTES = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_RESP = ST_RESP
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : Word storage with byte-enabled synchronous write, async read.
// Revision : 1.0
// ============================================================================
module dmem_array
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_widx,
    input  logic [WORD_BYTES-1:0] i_be,
    input  logic [31:0]           i_wdata,
    input  logic [IDX_W-1:0]      i_ridx,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Load/store responder with WAIT_STATES wait cycles and a one-cycle
//            response pulse. Define DMEM_BYTE_EN_EN for byte-enabled stores.
// Revision : 1.0
// ============================================================================
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2,
    parameter int IDX_W       = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
    input  logic [3:0]  req_be,
`endif
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam bit         c_NO_WAIT   = (WAIT_STATES == 0);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_res_rdata;
    logic        r_res_err;
    logic        r_resp_valid, r_resp_err;
    logic [31:0] r_resp_rdata;

    logic             w_accept, w_access, w_in_idle;
    logic [3:0]       w_req_be;
    logic             w_acc_we, w_acc_err;
    logic [31:0]      w_acc_addr, w_acc_wdata, w_rd_word;
    logic [3:0]       w_acc_be;
    logic [IDX_W-1:0] w_acc_idx;

`ifdef DMEM_BYTE_EN_EN
    assign w_req_be = req_be;
`else
    assign w_req_be = 4'b1111;
`endif

    assign w_in_idle = (r_state == S_IDLE);
    assign req_ready = w_in_idle && !Reset;
    assign w_accept  = req_valid && req_ready;

    // With zero wait states the access happens on the acceptance edge itself,
    // so it must see the live request rather than the captured copy.
    assign w_acc_we    = w_in_idle ? req_we    : r_we;
    assign w_acc_addr  = w_in_idle ? req_addr  : r_addr;
    assign w_acc_wdata = w_in_idle ? req_wdata : r_wdata;
    assign w_acc_be    = w_in_idle ? w_req_be  : r_be;
    assign w_acc_idx   = w_acc_addr[IDX_W+1:2];
    assign w_acc_err   = ((w_acc_addr[1:0] & ALIGN_MASK) != 2'b00) ||
                         (w_acc_addr[31:2] >= 30'(DEPTH_WORDS));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (c_NO_WAIT) begin
                        w_access    = 1'b1;
                        w_state_nxt = S_RESP;
                    end else begin
                        w_cnt_nxt   = c_WAIT_LOAD;
                        w_state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (Clk),
        .i_we    (w_access && w_acc_we && !w_acc_err && !Reset),
        .i_widx  (w_acc_idx),
        .i_be    (w_acc_be),
        .i_wdata (w_acc_wdata),
        .i_ridx  (w_acc_idx),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_res_rdata  <= 32'd0;
            r_res_err    <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= w_req_be;
            end
            if (w_access) begin
                r_res_err   <= w_acc_err;
                r_res_rdata <= (w_acc_err || w_acc_we) ? 32'd0 : w_rd_word;
            end
            // The pulse is registered out of RESP, one cycle after the access.
            r_resp_valid <= (r_state == S_RESP);
            r_resp_rdata <= (r_state == S_RESP) ? r_res_rdata : 32'd0;
            r_resp_err   <= (r_state == S_RESP) && r_res_err;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire
